// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between instruction fetch and data requesters.
// Optional MEM_ARB_RR_EN selects round-robin tie breaking; default is fixed data priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_rsp_valid,
  output logic [LINE_W-1:0] ic_rsp_data,
  input  logic              dc_req_valid,
  input  logic              dc_req_we,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_req_wdata,
  output logic              dc_req_ready,
  output logic              dc_rsp_valid,
  output logic [LINE_W-1:0] dc_rsp_data,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,
  output logic              busy,
  output logic              timeout_err,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises valid and holds valid plus all fields stable until it
  // sees ready; the transfer happens on the edge where valid && ready. Responses
  // (*_rsp_valid, mem_req_valid) are single-cycle pulses with no back-pressure.

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                owner_dc_q, owner_dc_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   ic_data_q, ic_data_d;
  logic [LINE_W-1:0]   dc_data_q, dc_data_d;
  logic                tmo_q, tmo_d;
  logic                grant_any, grant_dc, dc_wins;

`ifdef MEM_ARB_RR_EN
  // Remembers who was served last; on a tie the other requester wins.
  logic last_dc_q, last_dc_d;

  assign dc_wins   = dc_req_valid && (!ic_req_valid || !last_dc_q);
  assign last_dc_d = grant_any ? grant_dc : last_dc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_dc_q <= 1'b0;
    else      last_dc_q <= last_dc_d;
  end
`else
  assign dc_wins = dc_req_valid;
`endif

  always_comb begin
    state_d    = state_q;
    owner_dc_d = owner_dc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    ic_data_d  = ic_data_q;
    dc_data_d  = dc_data_q;
    tmo_d      = tmo_q;
    grant_any  = 1'b0;
    grant_dc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ic_req_valid || dc_req_valid) begin
          grant_any  = 1'b1;
          grant_dc   = dc_wins;
          owner_dc_d = dc_wins;
          we_d       = dc_wins & dc_req_we;
          addr_d     = dc_wins ? dc_req_addr : ic_req_addr;
          wdata_d    = dc_wins ? dc_req_wdata : '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (owner_dc_q) dc_data_d = mem_rsp_data;
          else            ic_data_d = mem_rsp_data;
          state_d = S_RESP;
        end else if (cnt_q == CNT_MAX) begin
          // Hung memory: hand the owner an all-zero line and flag it permanently.
          if (owner_dc_q) dc_data_d = '0;
          else            ic_data_d = '0;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      owner_dc_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      ic_data_q  <= '0;
      dc_data_q  <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_dc_q <= owner_dc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      ic_data_q  <= ic_data_d;
      dc_data_q  <= dc_data_d;
      tmo_q      <= tmo_d;
    end
  end

  // Readies are gated by reset so nothing looks accepted while reset is held.
  assign ic_req_ready  = rst & grant_any & ~grant_dc;
  assign dc_req_ready  = rst & grant_any & grant_dc;
  assign mem_req_valid = (state_q == S_ISSUE);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign ic_rsp_valid  = (state_q == S_RESP) & ~owner_dc_q;
  assign dc_rsp_valid  = (state_q == S_RESP) & owner_dc_q;
  assign ic_rsp_data   = ic_data_q;
  assign dc_rsp_data   = dc_data_q;
  assign busy          = (state_q != S_IDLE);
  assign timeout_err   = tmo_q;
  assign dbg_state     = state_q;

endmodule
